regfile_bypass_sb: RTL and testbench
====================================

// Module: regfile_bypass_sb
// PURPOSE
// - 8 x WIDTH general register bank with write-to-read bypass and a per-register pending-write scoreboard.
// - Feeds the decode-stage 8:1 operand select path: two read ports, one writeback port.
// - Issue logic raises stall when a read source still has an outstanding producer.
// - All 8 registers are ordinary storage; R0 is not hardwired.
// PARAMETERS
// - WIDTH  16  data width of each register and of the read/write data ports
// PORTS
// - clk          in   1      single clock, all state updates on rising edge
// - rst          in   1      synchronous, active-high reset
// - read1RegSel  in   3      read port 1 register index
// - read2RegSel  in   3      read port 2 register index
// - read1Use     in   1      port 1 operand is consumed this cycle (qualifies stall)
// - read2Use     in   1      port 2 operand is consumed this cycle (qualifies stall)
// - writeRegSel  in   3      writeback register index
// - writeData    in   WIDTH  writeback data
// - writeEn      in   1      commit writeData to writeRegSel at the clock edge; clears its pending bit
// - issueEn      in   1      an instruction issues that will later write issueRegSel
// - issueRegSel  in   3      destination of the issuing instruction
// - read1Data    out  WIDTH  port 1 data
// - read2Data    out  WIDTH  port 2 data
// - stall        out  1      read hazard on a pending register
// - pendMask     out  8      registered scoreboard, bit i = register i has an outstanding write
// - err          out  1      error flag
// BEHAVIOUR
// - Reset: when rst=1 at an edge, all regs become 0 and pendMask becomes 8'h00, overriding writeEn/issueEn that cycle.
// - Reset timing: rst mid-operation discards all pending state; outputs show the zeroed state the cycle after.
// - Write: on an edge with writeEn=1, regs[writeRegSel] <= writeData. Read ports are combinational, zero latency.
// - Bypass: readNData = (writeEn && writeRegSel==readNRegSel) ? writeData : regs[readNRegSel].
// - Bypass covers both ports at once, including read1RegSel==read2RegSel==writeRegSel.
// - Scoreboard next state, per bit i:
//   - set if issueEn && issueRegSel==i;
//   - else cleared if writeEn && writeRegSel==i;
//   - else held.
// - Set wins over clear for the same register in the same cycle, because the new producer supersedes the old one.
// - Issue and write to different registers in one cycle both take effect.
// - hazN = readNUse && pendMask[readNRegSel] && !(writeEn && writeRegSel==readNRegSel).
//   The write being committed this cycle resolves the hazard through the bypass.
// - stall = haz1 | haz2. stall is combinational from the registered pendMask and current inputs.
// - Same-cycle issueEn does not affect stall; it only affects pendMask for the following cycle.
// - err = 1 when any of the following holds:
//   - any select, enable or use input is X/Z (reduction-XOR ===1'bx check);
//   - issueEn && stall (issue past an unresolved hazard);
//   - writeEn to a register whose pendMask bit is 0 (writeback with no producer).
// - err is a checker output only; it never blocks a state update.
// - Width rules: indices are exactly 3 bits, so there is no out-of-range case. Data is stored unmodified with no extension.
// STRUCTURE
// - Shared package: constant NUM_REGS=8, constant REG_IDX_W=3, default WIDTH=16.
// - Sub-module reg_en: WIDTH-bit register with synchronous active-high reset and load enable; 8 instances.
// - Read path: per port, an 8:1 WIDTH-bit select followed by the 2:1 bypass select.
// - Scoreboard: 8 single-bit flops built from the reg_en sub-module with WIDTH=1.
// TESTING
// - Reset then read all 8 regs on both ports -> every read is 16'h0000; pendMask=8'h00; stall=0; err=0.
// - Write R3=16'hBEEF with writeEn, then read R3 next cycle -> read1Data=16'hBEEF.
// - Same-cycle bypass: write R5=16'h1234 while read1RegSel=read2RegSel=5 -> both ports show 16'h1234 in that cycle.
// - Stall path:
//   - issue R2, next cycle read1RegSel=2 with read1Use=1 -> stall=1;
//   - with read1Use=0 -> stall=0;
//   - writeback R2=16'h00AA in the same cycle -> stall=0 and read1Data=16'h00AA.
// - Simultaneous events: pendMask[4]=1, then issueEn and writeEn both to R4 in one cycle -> pendMask[4] stays 1 and R4 takes the written data.
// - Error and reset: writeEn to R6 with pendMask[6]=0 -> err=1; issueEn with stall=1 -> err=1.
//   Assert rst while pendMask=8'hFF -> pendMask=8'h00 and all regs 0 on the next cycle.

Source files
------------

// File: rtl/regfile_bypass_sb_pkg.sv
// Shared constants for the bypassed register bank with pending-write scoreboard.
package regfile_bypass_sb_pkg;

  localparam int NUM_REGS      = 8;
  localparam int REG_IDX_W     = 3;
  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/regfile_bypass_sb_reg_en.sv
// Load-enabled register with synchronous active-high reset; used for data and scoreboard bits.
module regfile_bypass_sb_reg_en #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/regfile_bypass_sb.sv
// 8-entry register bank: two bypassed combinational read ports, one writeback port,
// and a per-register pending-write scoreboard that drives the issue stall.
module regfile_bypass_sb
  import regfile_bypass_sb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] read1RegSel,
  input  logic [REG_IDX_W-1:0] read2RegSel,
  input  logic                 read1Use,
  input  logic                 read2Use,
  input  logic [REG_IDX_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0]     writeData,
  input  logic                 writeEn,
  input  logic                 issueEn,
  input  logic [REG_IDX_W-1:0] issueRegSel,
  output logic [WIDTH-1:0]     read1Data,
  output logic [WIDTH-1:0]     read2Data,
  output logic                 stall,
  output logic [NUM_REGS-1:0]  pendMask,
  output logic                 err
);

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] iss_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bank
      assign wr_hit[gi]  = writeEn && (writeRegSel == REG_IDX_W'(gi));
      assign iss_hit[gi] = issueEn && (issueRegSel == REG_IDX_W'(gi));

      regfile_bypass_sb_reg_en #(.W(WIDTH)) u_data (
        .clk  (clk),
        .rst  (rst),
        .en_i (wr_hit[gi]),
        .d_i  (writeData),
        .q_o  (regs_q[gi])
      );

      // Loading iss_hit makes a new producer win over a same-cycle writeback.
      regfile_bypass_sb_reg_en #(.W(1)) u_pend (
        .clk  (clk),
        .rst  (rst),
        .en_i (iss_hit[gi] | wr_hit[gi]),
        .d_i  (iss_hit[gi]),
        .q_o  (pendMask[gi])
      );
    end
  endgenerate

  logic byp1, byp2, haz1, haz2, x_in;

  assign byp1 = writeEn && (writeRegSel == read1RegSel);
  assign byp2 = writeEn && (writeRegSel == read2RegSel);

  assign read1Data = byp1 ? writeData : regs_q[read1RegSel];
  assign read2Data = byp2 ? writeData : regs_q[read2RegSel];

  // A commit in this cycle resolves the hazard through the bypass.
  assign haz1  = read1Use && pendMask[read1RegSel] && !byp1;
  assign haz2  = read2Use && pendMask[read2RegSel] && !byp2;
  assign stall = haz1 | haz2;

  assign x_in = ((^{read1RegSel, read2RegSel, read1Use, read2Use, writeRegSel,
                    writeEn, issueEn, issueRegSel}) === 1'bx);

  assign err = x_in
             | (issueEn && stall)
             | (writeEn && !pendMask[writeRegSel]);

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb with hand-computed expected values.
module tb_regfile_bypass_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  read1RegSel, read2RegSel, writeRegSel, issueRegSel;
  logic        read1Use, read2Use, writeEn, issueEn;
  logic [15:0] writeData;
  logic [15:0] read1Data, read2Data;
  logic        stall, err;
  logic [7:0]  pendMask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_bypass_sb #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .read1Use    (read1Use),
    .read2Use    (read2Use),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .issueEn     (issueEn),
    .issueRegSel (issueRegSel),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .stall       (stall),
    .pendMask    (pendMask),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    writeEn = 0; issueEn = 0; read1Use = 0; read2Use = 0;
    writeRegSel = 0; issueRegSel = 0; writeData = 0;
  endtask

  initial begin
    rst = 1; read1RegSel = 0; read2RegSel = 0;
    idle();
    tick();
    rst = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      read1RegSel = 3'(i); read2RegSel = 3'(7 - i);
      #1;
      check($sformatf("rst_rd1_r%0d", i), 32'(read1Data), 32'h0);
      check($sformatf("rst_rd2_r%0d", 7 - i), 32'(read2Data), 32'h0);
    end
    check("rst_pend", 32'(pendMask), 32'h00);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    // write R3 then read next cycle
    writeEn = 1; writeRegSel = 3; writeData = 16'hBEEF;
    tick();
    idle(); read1RegSel = 3;
    #1;
    check("wr_r3", 32'(read1Data), 32'hBEEF);

    // same-cycle bypass on both ports
    writeEn = 1; writeRegSel = 5; writeData = 16'h1234;
    read1RegSel = 5; read2RegSel = 5;
    #1;
    check("byp_rd1", 32'(read1Data), 32'h1234);
    check("byp_rd2", 32'(read2Data), 32'h1234);
    tick();
    idle();
    #1;
    check("r5_after", 32'(read1Data), 32'h1234);

    // stall path on R2
    issueEn = 1; issueRegSel = 2;
    tick();
    idle();
    #1;
    check("iss_r2_pend", 32'(pendMask), 32'h04);
    read1RegSel = 2; read2RegSel = 0; read1Use = 1;
    #1;
    check("stall_use", 32'(stall), 32'h1);
    read1Use = 0;
    #1;
    check("stall_nouse", 32'(stall), 32'h0);
    read1Use = 1; writeEn = 1; writeRegSel = 2; writeData = 16'h00AA;
    #1;
    check("stall_wb", 32'(stall), 32'h0);
    check("wb_byp", 32'(read1Data), 32'h00AA);
    check("wb_err", 32'(err), 32'h0);
    tick();
    idle();
    #1;
    check("wb_pend_clr", 32'(pendMask), 32'h00);

    // simultaneous issue and write to R4
    issueEn = 1; issueRegSel = 4;
    tick();
    idle();
    #1;
    check("iss_r4_pend", 32'(pendMask), 32'h10);
    issueEn = 1; issueRegSel = 4; writeEn = 1; writeRegSel = 4; writeData = 16'h5555;
    #1;
    check("sim_err", 32'(err), 32'h0);
    tick();
    idle(); read1RegSel = 4;
    #1;
    check("sim_pend", 32'(pendMask), 32'h10);
    check("sim_data", 32'(read1Data), 32'h5555);

    // write with no producer
    writeEn = 1; writeRegSel = 6; writeData = 16'h0001;
    #1;
    check("err_noprod", 32'(err), 32'h1);
    tick();
    idle();
    #1;
    check("err_clear", 32'(err), 32'h0);

    // issue past a hazard on port 2
    read2RegSel = 4; read2Use = 1; issueEn = 1; issueRegSel = 1;
    #1;
    check("haz2_stall", 32'(stall), 32'h1);
    check("err_iss_stall", 32'(err), 32'h1);
    tick();
    idle();
    #1;
    check("iss_r1_pend", 32'(pendMask), 32'h12);

    // fill scoreboard, then reset overrides same-cycle write and issue
    for (int i = 0; i < 8; i++) begin
      issueEn = 1; issueRegSel = 3'(i);
      tick();
    end
    idle();
    #1;
    check("pend_full", 32'(pendMask), 32'hFF);
    rst = 1; writeEn = 1; writeRegSel = 7; writeData = 16'hFFFF;
    issueEn = 1; issueRegSel = 0;
    tick();
    rst = 0;
    idle();
    #1;
    check("rst2_pend", 32'(pendMask), 32'h00);
    for (int i = 0; i < 8; i++) begin
      read1RegSel = 3'(i); read2RegSel = 3'(i);
      #1;
      check($sformatf("rst2_rd1_r%0d", i), 32'(read1Data), 32'h0);
      check($sformatf("rst2_rd2_r%0d", i), 32'(read2Data), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
